ifetch_unit: RTL and testbench

Instruction-fetch front end that produces the `pc`/`inst` pair captured each cycle by the IF/ID pipeline register. It generates sequential and redirected fetch addresses and drives a req/ack instruction-memory port with at most one request outstanding. A one-entry skid buffer lets it sustain one instruction per cycle across stalls, and it implements the MIPS branch-delay-slot redirect.

---
 rtl/ifetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction-fetch front end feeding the IF/ID pipeline register.
// Generates sequential and redirected fetch addresses, drives a req/ack
// instruction-memory port with at most one request in flight, buffers one
// extra instruction in a skid entry so a stall never loses data, and
// implements the MIPS branch-delay-slot redirect.
//
// Parameters:
//   RESET_PC        first fetch address after reset (low two bits ignored)
// Ports:
//   clk             clock, all state on posedge
//   resetn          synchronous active-low reset
//   jmp/jmp_target  redirect request from ID (acted on only when the slot is taken)
//   hazard_stall    ID hold
//   exe_stall       EX hold
//   cond_exe_stall  IF/ID flush, presented instruction discarded
//   imem_req        fetch request
//   imem_addr       word-aligned fetch address
//   imem_ack        response valid (ignored while imem_req=0)
//   imem_rdata      instruction returned with imem_ack
//   pc/inst         presented instruction address/word, 0 when not valid
//   fetch_valid     pc/inst hold a real instruction
//   fetch_misalign  only with IFETCH_ALIGN_CHECK_EN: sticky misaligned-redirect flag
//
// Configuration macro: IFETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target stops fetching and
//               raises fetch_misalign until the next aligned redirect
//   undefined : jmp_target[1:0] is treated as 2'b00 and fetch_misalign is absent

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        hazard_stall,
    input  logic        exe_stall,
    input  logic        cond_exe_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic        fetch_valid
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_FULL = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam logic [2:0] ST_MIS  = 3'd4;

    logic [2:0]  state_r, state_n;

    logic [31:0] out_pc_r, out_pc_n;
    logic [31:0] out_inst_r, out_inst_n;
    logic        out_v_r, out_v_n;
    logic [31:0] sk_pc_r, sk_pc_n;
    logic [31:0] sk_inst_r, sk_inst_n;
    logic        sk_v_r, sk_v_n;
    logic [31:0] next_pc_r, next_pc_n;
    logic        redir_pend_r, redir_pend_n;
    logic [31:0] redir_pc_r, redir_pc_n;
    logic        mis_r, mis_n;

    logic        take_s;
    logic        ack_s;
    logic        deliver_s;
    logic        redir_s;
    logic        case1_s;
    logic        case2_s;
    logic [31:0] tgt_s;
    logic        tgt_bad_s;

    // Redirect target qualification (alignment handling depends on build)
`ifdef IFETCH_ALIGN_CHECK_EN
    assign tgt_s     = jmp_target;
    assign tgt_bad_s = |jmp_target[1:0];
`else
    assign tgt_s     = jmp_target & 32'hFFFF_FFFC;
    assign tgt_bad_s = 1'b0;
`endif

    // The output slot is released when ID takes it or the slot is flushed.
    assign take_s    = cond_exe_stall | ~(hazard_stall | exe_stall);
    assign ack_s     = imem_req & imem_ack;
    // Only acks in REQ carry useful data; DROP acks are discarded.
    assign deliver_s = ack_s & (state_r == ST_REQ);
    assign redir_s   = jmp & take_s & (state_r != ST_IDLE);
    // Case 1: the presented instruction is the delay slot.
    // Case 2: the in-flight request is the delay slot.
    assign case1_s   = redir_s & out_v_r;
    assign case2_s   = redir_s & ~out_v_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                state_n = ST_REQ;
            end
            ST_REQ: begin
                if (case1_s) begin
                    // Without an ack the outstanding request must be drained first.
                    if (ack_s) begin
                        state_n = mis_n ? ST_MIS : ST_REQ;
                    end else begin
                        state_n = ST_DROP;
                    end
                end else if (sk_v_n) begin
                    state_n = ST_FULL;
                end else if (ack_s && mis_n && (redir_pend_r || case2_s)) begin
                    // Delay slot delivered; the pending target is misaligned.
                    state_n = ST_MIS;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_FULL: begin
                if (case1_s) begin
                    state_n = mis_n ? ST_MIS : ST_REQ;
                end else if (take_s) begin
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_FULL;
                end
            end
            ST_DROP: begin
                if (ack_s) begin
                    state_n = mis_n ? ST_MIS : ST_REQ;
                end else begin
                    state_n = ST_DROP;
                end
            end
            ST_MIS: begin
                if (redir_s && !tgt_bad_s) begin
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_MIS;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: memory port is a pure decode of registered state
    always_comb begin
        imem_req  = (state_r == ST_REQ) || (state_r == ST_DROP);
        imem_addr = {next_pc_r[31:2], 2'b00};
    end

    // Datapath next values: output slot, skid entry, fetch and redirect addresses
    always_comb begin
        out_pc_n     = out_pc_r;
        out_inst_n   = out_inst_r;
        out_v_n      = out_v_r;
        sk_pc_n      = sk_pc_r;
        sk_inst_n    = sk_inst_r;
        sk_v_n       = sk_v_r;
        next_pc_n    = next_pc_r;
        redir_pend_n = redir_pend_r;
        redir_pc_n   = redir_pc_r;
        mis_n        = mis_r;
        case (state_r)
            ST_IDLE: begin
                next_pc_n = next_pc_r;
            end
            ST_MIS: begin
                if (redir_s) begin
                    next_pc_n = tgt_s;
                    mis_n     = tgt_bad_s;
                end else begin
                    mis_n     = mis_r;
                end
            end
            default: begin
                if (case1_s) begin
                    // Delay slot consumed; anything fetched after it is stale.
                    out_pc_n     = 32'h0000_0000;
                    out_inst_n   = 32'h0000_0000;
                    out_v_n      = 1'b0;
                    sk_pc_n      = 32'h0000_0000;
                    sk_inst_n    = 32'h0000_0000;
                    sk_v_n       = 1'b0;
                    redir_pend_n = 1'b0;
                    redir_pc_n   = tgt_s;
                    mis_n        = tgt_bad_s;
                    if (imem_req && !ack_s) begin
                        // Keep presenting the old address until it is acked.
                        next_pc_n = next_pc_r;
                    end else begin
                        next_pc_n = tgt_s;
                    end
                end else begin
                    if (take_s && sk_v_r) begin
                        out_pc_n   = sk_pc_r;
                        out_inst_n = sk_inst_r;
                        out_v_n    = 1'b1;
                        if (deliver_s) begin
                            sk_pc_n   = next_pc_r;
                            sk_inst_n = imem_rdata;
                        end else begin
                            sk_pc_n   = 32'h0000_0000;
                            sk_inst_n = 32'h0000_0000;
                            sk_v_n    = 1'b0;
                        end
                    end else if ((take_s || !out_v_r) && deliver_s) begin
                        out_pc_n   = next_pc_r;
                        out_inst_n = imem_rdata;
                        out_v_n    = 1'b1;
                    end else if (take_s) begin
                        out_pc_n   = 32'h0000_0000;
                        out_inst_n = 32'h0000_0000;
                        out_v_n    = 1'b0;
                    end else if (deliver_s) begin
                        sk_pc_n   = next_pc_r;
                        sk_inst_n = imem_rdata;
                        sk_v_n    = 1'b1;
                    end else begin
                        out_v_n = out_v_r;
                    end

                    if (ack_s) begin
                        if (state_r == ST_DROP) begin
                            next_pc_n = redir_pc_r;
                        end else if (redir_pend_r) begin
                            next_pc_n    = redir_pc_r;
                            redir_pend_n = 1'b0;
                        end else begin
                            next_pc_n = next_pc_r + 32'd4;
                        end
                    end else begin
                        next_pc_n = next_pc_r;
                    end

                    if (case2_s) begin
                        mis_n = tgt_bad_s;
                        if (ack_s) begin
                            // The delay slot arrives this very cycle.
                            next_pc_n    = tgt_s;
                            redir_pend_n = 1'b0;
                        end else begin
                            redir_pc_n   = tgt_s;
                            redir_pend_n = (state_r == ST_REQ);
                        end
                    end else begin
                        redir_pc_n = redir_pc_n;
                    end
                end
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_pc_r     <= 32'h0000_0000;
            out_inst_r   <= 32'h0000_0000;
            out_v_r      <= 1'b0;
            sk_pc_r      <= 32'h0000_0000;
            sk_inst_r    <= 32'h0000_0000;
            sk_v_r       <= 1'b0;
            next_pc_r    <= RESET_PC & 32'hFFFF_FFFC;
            redir_pend_r <= 1'b0;
            redir_pc_r   <= 32'h0000_0000;
            mis_r        <= 1'b0;
        end else begin
            out_pc_r     <= out_pc_n;
            out_inst_r   <= out_inst_n;
            out_v_r      <= out_v_n;
            sk_pc_r      <= sk_pc_n;
            sk_inst_r    <= sk_inst_n;
            sk_v_r       <= sk_v_n;
            next_pc_r    <= next_pc_n;
            redir_pend_r <= redir_pend_n;
            redir_pc_r   <= redir_pc_n;
            mis_r        <= mis_n;
        end
    end

    assign pc          = out_pc_r;
    assign inst        = out_inst_r;
    assign fetch_valid = out_v_r;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fetch_misalign = mis_r;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit with RESET_PC = 0x100.
// Memory returns inst = addr ^ 0xC0DE_0000; ack timing comes from the table.

module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        hazard_stall;
    logic        exe_stall;
    logic        cond_exe_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

    ifetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .jmp            (jmp),
        .jmp_target     (jmp_target),
        .hazard_stall   (hazard_stall),
        .exe_stall      (exe_stall),
        .cond_exe_stall (cond_exe_stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .inst           (inst),
`ifdef IFETCH_ALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .fetch_valid    (fetch_valid)
    );

    typedef struct {
        logic        jmp;
        logic [31:0] tgt;
        logic        hz;
        logic        ex;
        logic        cx;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic j, input logic [31:0] t, input logic hz, input logic ex,
                       input logic cx, input logic ack, input logic req, input logic [31:0] addr,
                       input logic v, input logic [31:0] p, input logic [31:0] i);
        vec_t e;
        e.jmp = j; e.tgt = t; e.hz = hz; e.ex = ex; e.cx = cx; e.ack = ack;
        e.req = req; e.addr = addr; e.v = v; e.pc = p; e.inst = i;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] p, input logic [31:0] i);
        chk({tag, ".req"},  {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".addr"}, imem_addr,            addr);
        chk({tag, ".v"},    {31'd0, fetch_valid}, {31'd0, v});
        chk({tag, ".pc"},   pc,                   p);
        chk({tag, ".inst"}, inst,                 i);
    endtask

    initial begin
        //   jmp tgt            hz    ex    cx    ack  | req addr           v     pc             inst
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'hC0DE_0100);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'hC0DE_0104);
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0108, 32'hC0DE_0108);
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0110, 1'b1, 32'h0000_0108, 32'hC0DE_0108);
        add(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0110, 1'b1, 32'h0000_0108, 32'hC0DE_0108);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0110, 1'b1, 32'h0000_0108, 32'hC0DE_0108);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_010C, 32'hC0DE_010C);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0114, 1'b1, 32'h0000_0110, 32'hC0DE_0110);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0114, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0114, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0114, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0118, 1'b1, 32'h0000_0114, 32'hC0DE_0114);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0118, 1'b0, 32'h0,         32'h0);
        add(1'b1, 32'h2000,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_011C, 1'b1, 32'h0000_0118, 32'hC0DE_0118);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_011C, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_011C, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000, 32'hC0DE_2000);
        add(1'b1, 32'h3000,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2004, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2004, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_2004, 32'hC0DE_2004);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 1'b1, 32'h0000_3000, 32'hC0DE_3000);
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3004, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3008, 1'b1, 32'h0000_3004, 32'hC0DE_3004);
        add(1'b1, 32'h4000,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_300C, 1'b1, 32'h0000_3004, 32'hC0DE_3004);
        add(1'b1, 32'h4000,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_300C, 1'b1, 32'h0000_3004, 32'hC0DE_3004);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'h0,         32'h0);
        add(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4004, 1'b1, 32'h0000_4000, 32'hC0DE_4000);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4004, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC);
        add(1'b1, 32'h5000,     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'hC0DE_0000);
        add(1'b1, 32'h6002,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0,         32'h0);
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 32'h0,         32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 1'b1, 32'h0000_5000, 32'hC0DE_5000);
`else
        add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6000, 1'b1, 32'h0000_5000, 32'hC0DE_5000);
`endif

        resetn = 1'b0; jmp = 1'b0; jmp_target = 32'h0;
        hazard_stall = 1'b0; exe_stall = 1'b0; cond_exe_stall = 1'b0; imem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("reset.misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
        resetn = 1'b1;

        // Each row: drive inputs for this cycle, check outputs mid-cycle, advance.
        for (int i = 0; i < vq.size(); i++) begin
            jmp = vq[i].jmp; jmp_target = vq[i].tgt;
            hazard_stall = vq[i].hz; exe_stall = vq[i].ex;
            cond_exe_stall = vq[i].cx; imem_ack = vq[i].ack;
            @(negedge clk);
            chk_outs($sformatf("v%0d", i), vq[i].req, vq[i].addr, vq[i].v, vq[i].pc, vq[i].inst);
            @(posedge clk);
            #1;
        end
        jmp = 1'b0; imem_ack = 1'b0;

`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis.flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis.req",  {31'd0, imem_req},       32'd0);
        // Aligned redirect clears the flag and resumes fetching at the target.
        jmp = 1'b1; jmp_target = 32'h0000_7000;
        @(posedge clk);
        #1;
        jmp = 1'b0;
        chk("mis.clear", {31'd0, fetch_misalign}, 32'd0);
        chk("mis.resume.req", {31'd0, imem_req}, 32'd1);
        chk("mis.resume.addr", imem_addr, 32'h0000_7000);
`endif

        // Reset in the middle of an outstanding request abandons it.
        imem_ack = 1'b1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk_outs("midreset", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel.c1.req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel.c2.req",  {31'd0, imem_req}, 32'd1);
        chk("rel.c2.addr", imem_addr,         32'h0000_0100);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk_outs("rel.first", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'hC0DE_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
